one_dim_convol_feeder: RTL and testbench

- Transmit side of the convolution kernel's sample interface.
- Accepts framed samples from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Drives the kernel's sample/enable inputs as gap-free bursts, then appends WINDOW_SIZE-1 zero samples per frame so the kernel produces the full-length convolution tail and starts every frame with a clean window.
- Sits directly upstream of the kernel, inside the convolution datapath top.

---
 rtl/settings_pkg.sv | 20 ++
 rtl/convol_sync_fifo.sv | 59 +++++
 rtl/one_dim_convol_feeder.sv | 153 +++++++++++++++
 tb/tb_one_dim_convol_feeder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared constants and types for the convolution datapath
// Purpose: sample/kernel sizing, feeder FIFO sizing, feeder FSM state and
//          FIFO entry types used by the feeder and its FIFO.
// Ports:   none (package).
package settings_pkg;

  localparam int DATA_SIZE      = 16;
  localparam int WINDOW_SIZE    = 8;
  localparam int FIFO_DEPTH     = 16;
  localparam int START_LEVEL    = 4;
  localparam int FLUSH_CNT_SIZE = $clog2(WINDOW_SIZE);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} feeder_state_t;

  typedef struct packed {
    logic                 last;
    logic [DATA_SIZE-1:0] data;
  } feeder_entry_t;

endpackage

// File: rtl/convol_sync_fifo.sv
// rtl/convol_sync_fifo.sv - first-word fall-through sample FIFO for the feeder
// Purpose: stores {last, data} entries between the upstream handshake and the
//          feeder FSM; the head entry is always visible on dout.
// Ports:   clk, reset (sync, active-high), push/din write side,
//          pop/dout read side, count occupancy, full, empty.
module convol_sync_fifo
  import settings_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  feeder_entry_t     din,
  output feeder_entry_t     dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  feeder_entry_t     mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Guard against misuse so pointers can never overrun each other.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/one_dim_convol_feeder.sv
// rtl/one_dim_convol_feeder.sv - sample feeder in front of the 1-D convolution kernel
// Purpose: buffers framed upstream samples, streams them gap-free to the kernel
//          and appends WINDOW_SIZE-1 zero samples after each frame.
// Ports:   clk, reset (sync, active-high);
//          s_data/s_valid/s_last/s_ready upstream handshake;
//          conv_data/conv_enable registered kernel inputs;
//          frame_done pulse on last flush zero, busy, underrun pulse,
//          underrun_flag sticky until reset.
module one_dim_convol_feeder
  import settings_pkg::*;
#(
  parameter int FIFO_DEPTH  = settings_pkg::FIFO_DEPTH,
  parameter int START_LEVEL = settings_pkg::START_LEVEL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [DATA_SIZE-1:0] conv_data,
  output logic                 conv_enable,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 underrun,
  output logic                 underrun_flag
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]          START_CNT  = CNT_W'(START_LEVEL);
  localparam logic [FLUSH_CNT_SIZE-1:0] FLUSH_LOAD = FLUSH_CNT_SIZE'(WINDOW_SIZE - 1);

  feeder_state_t             state;
  feeder_state_t             state_n;
  logic [FLUSH_CNT_SIZE-1:0] flush_cnt;
  logic [FLUSH_CNT_SIZE-1:0] flush_n;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          last_cnt;
  logic                      full;
  logic                      empty;
  logic                      reset_q;
  logic                      push;
  logic                      pop;
  logic                      start_ok;
  feeder_entry_t             din;
  feeder_entry_t             head;
  logic [DATA_SIZE-1:0]      data_n;
  logic                      enable_n;
  logic                      done_n;
  logic                      underrun_n;

  // reset_q keeps s_ready low for the cycle right after reset is released,
  // so nothing is accepted while the FIFO is coming out of reset.
  assign s_ready  = !reset_q && !full;
  assign push     = s_valid && s_ready;
  assign din.last = s_last;
  assign din.data = s_data;

  // A complete frame in the FIFO may start even below the start level.
  assign start_ok = (count >= START_CNT) || (last_cnt != '0);

  convol_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    pop        = 1'b0;
    state_n    = state;
    flush_n    = flush_cnt;
    data_n     = '0;
    enable_n   = 1'b0;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          pop      = 1'b1;
          data_n   = head.data;
          enable_n = 1'b1;
          if (head.last) begin
            state_n = FLUSH;
            flush_n = FLUSH_LOAD;
          end else begin
            state_n = STREAM;
          end
        end
      end
      STREAM: begin
        if (!empty) begin
          pop      = 1'b1;
          data_n   = head.data;
          enable_n = 1'b1;
          if (head.last) begin
            state_n = FLUSH;
            flush_n = FLUSH_LOAD;
          end
        end else begin
          underrun_n = 1'b1;
        end
      end
      FLUSH: begin
        enable_n = 1'b1;
        flush_n  = flush_cnt - FLUSH_CNT_SIZE'(1);
        if (flush_cnt == FLUSH_CNT_SIZE'(1)) begin
          done_n = 1'b1;
          // When the next frame is already eligible, skip IDLE: STREAM pops
          // it on the following cycle, right behind the last zero.
          state_n = start_ok ? STREAM : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_q       <= 1'b1;
      state         <= IDLE;
      flush_cnt     <= '0;
      last_cnt      <= '0;
      conv_data     <= '0;
      conv_enable   <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
      underrun      <= 1'b0;
      underrun_flag <= 1'b0;
    end else begin
      reset_q       <= 1'b0;
      state         <= state_n;
      flush_cnt     <= flush_n;
      last_cnt      <= last_cnt + CNT_W'(push && s_last) - CNT_W'(pop && head.last);
      conv_data     <= data_n;
      conv_enable   <= enable_n;
      frame_done    <= done_n;
      busy          <= (state_n != IDLE);
      underrun      <= underrun_n;
      underrun_flag <= underrun_flag | underrun_n;
    end
  end

endmodule

// File: tb/tb_one_dim_convol_feeder.sv
// tb/tb_one_dim_convol_feeder.sv - self-checking bench for one_dim_convol_feeder
module tb_one_dim_convol_feeder;
  import settings_pkg::*;

  localparam int DW        = DATA_SIZE;
  localparam int FLUSH_LEN = WINDOW_SIZE - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          sel4;

  logic          s_ready_a, conv_enable_a, frame_done_a, busy_a, underrun_a, flag_a;
  logic [DW-1:0] conv_data_a;
  logic          s_ready_b, conv_enable_b, frame_done_b, busy_b, underrun_b, flag_b;
  logic [DW-1:0] conv_data_b;

  one_dim_convol_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (in_data),
    .s_valid       (in_valid && !sel4),
    .s_last        (in_last),
    .s_ready       (s_ready_a),
    .conv_data     (conv_data_a),
    .conv_enable   (conv_enable_a),
    .frame_done    (frame_done_a),
    .busy          (busy_a),
    .underrun      (underrun_a),
    .underrun_flag (flag_a)
  );

  one_dim_convol_feeder #(
    .FIFO_DEPTH  (4),
    .START_LEVEL (4)
  ) dut4 (
    .clk           (clk),
    .reset         (reset),
    .s_data        (in_data),
    .s_valid       (in_valid && sel4),
    .s_last        (in_last),
    .s_ready       (s_ready_b),
    .conv_data     (conv_data_b),
    .conv_enable   (conv_enable_b),
    .frame_done    (frame_done_b),
    .busy          (busy_b),
    .underrun      (underrun_b),
    .underrun_flag (flag_b)
  );

  logic          m_ready, m_enable, m_done, m_busy, m_underrun, m_flag;
  logic [DW-1:0] m_data;
  assign m_ready    = sel4 ? s_ready_b     : s_ready_a;
  assign m_enable   = sel4 ? conv_enable_b : conv_enable_a;
  assign m_done     = sel4 ? frame_done_b  : frame_done_a;
  assign m_busy     = sel4 ? busy_b        : busy_a;
  assign m_underrun = sel4 ? underrun_b    : underrun_a;
  assign m_flag     = sel4 ? flag_b        : flag_a;
  assign m_data     = sel4 ? conv_data_b   : conv_data_a;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] push_data[$];
  logic          push_last[$];
  int            push_edge[$];
  logic [DW-1:0] out_data[$];
  logic          out_done[$];
  int            out_edge[$];
  int            n_bubble, n_underrun, n_ready_low, stray_done;

  task automatic clear_sb();
    push_data.delete(); push_last.delete(); push_edge.delete();
    out_data.delete(); out_done.delete(); out_edge.delete();
    n_bubble = 0; n_underrun = 0; n_ready_low = 0; stray_done = 0;
  endtask

  // One clock: record the handshake seen before the edge, then the
  // registered outputs 1 time unit after it.
  task automatic step();
    if (in_valid && !m_ready) n_ready_low++;
    if (in_valid && m_ready) begin
      push_data.push_back(in_data);
      push_last.push_back(in_last);
      push_edge.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (m_enable) begin
      out_data.push_back(m_data);
      out_done.push_back(m_done);
      out_edge.push_back(cyc);
    end else if (m_done) begin
      stray_done++;
    end
    if (m_busy && !m_enable) n_bubble++;
    if (m_underrun) n_underrun++;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    int guard = 0;
    in_data = d; in_last = l; in_valid = 1'b1;
    while (!m_ready && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      total++; bad++;
      $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles, required 1", guard);
    end
    step();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    in_valid = 1'b0;
    step(); step();
    while ((m_busy || m_enable) && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", m_busy, guard);
    end
    step();
  endtask

  // Reference: every pushed sample comes out in order; each frame's last
  // sample is followed by FLUSH_LEN zeros, frame_done on the final zero.
  task automatic check_seq(input string name);
    logic [DW-1:0] ed[$];
    logic          edn[$];
    for (int i = 0; i < push_data.size(); i++) begin
      ed.push_back(push_data[i]);
      edn.push_back(1'b0);
      if (push_last[i]) begin
        for (int k = 1; k <= FLUSH_LEN; k++) begin
          ed.push_back('0);
          edn.push_back(k == FLUSH_LEN);
        end
      end
    end
    total++;
    if (out_data.size() != ed.size()) begin
      bad++;
      $display("FAIL %s length: got %0d enabled samples, required %0d", name, out_data.size(), ed.size());
    end
    for (int i = 0; i < ed.size() && i < out_data.size(); i++) begin
      total++;
      if (out_data[i] !== ed[i] || out_done[i] !== edn[i]) begin
        bad++;
        $display("FAIL %s sample %0d: got data=%0h done=%0b, required data=%0h done=%0b",
                 name, i, out_data[i], out_done[i], ed[i], edn[i]);
      end
    end
    total++;
    if (stray_done != 0) begin
      bad++;
      $display("FAIL %s stray_done: got %0d frame_done without enable, required 0", name, stray_done);
    end
  endtask

  task automatic check_contig(input string name, input int len);
    total++;
    if (out_edge.size() != len) begin
      bad++;
      $display("FAIL %s burst_len: got %0d enabled cycles, required %0d", name, out_edge.size(), len);
    end else if (out_edge[len-1] - out_edge[0] != len - 1) begin
      bad++;
      $display("FAIL %s gap: burst spans %0d cycles, required %0d", name, out_edge[len-1] - out_edge[0] + 1, len);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({m_ready, s_ready_b, m_enable, m_done, m_busy, m_underrun, m_flag} !== 7'b0 || m_data !== '0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: ready=%0b/%0b en=%0b done=%0b busy=%0b und=%0b flag=%0b data=%0h, required all 0",
                 i, m_ready, s_ready_b, m_enable, m_done, m_busy, m_underrun, m_flag, m_data);
      end
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; reset = 1'b0;
    step();
    total++;
    if (m_ready !== 1'b1 || s_ready_b !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: s_ready=%0b/%0b, required 1/1", m_ready, s_ready_b);
    end
    clear_sb();
  endtask

  task automatic test_single_frame();
    clear_sb();
    for (int i = 1; i <= 5; i++) send(DW'(i), i == 5);
    wait_idle();
    check_seq("single_frame");
    check_contig("single_frame", 5 + FLUSH_LEN);
    // Start level reached by the 4th write; one more edge to pop it.
    total++;
    if (push_edge.size() < 4 || out_edge.size() == 0 || out_edge[0] != push_edge[3] + 1) begin
      bad++;
      $display("FAIL single_frame latency: first output edge %0d, required %0d",
               out_edge.size() ? out_edge[0] : -1, push_edge.size() >= 4 ? push_edge[3] + 1 : -1);
    end
    total++;
    if (n_bubble != 0 || n_underrun != 0) begin
      bad++;
      $display("FAIL single_frame bubbles: got %0d bubbles %0d underruns, required 0", n_bubble, n_underrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] v[5];
    int            ndone = 0;
    v[0] = 10; v[1] = 11; v[2] = 20; v[3] = 21; v[4] = 22;
    clear_sb();
    for (int i = 0; i < 5; i++) send(v[i], (i == 1) || (i == 4));
    wait_idle();
    check_seq("back_to_back");
    check_contig("back_to_back", 5 + 2 * FLUSH_LEN);
    foreach (out_done[i]) if (out_done[i]) ndone++;
    total++;
    if (ndone != 2) begin
      bad++;
      $display("FAIL back_to_back frame_done: got %0d pulses, required 2", ndone);
    end
    total++;
    if (push_edge.size() < 2 || out_edge.size() == 0 || out_edge[0] != push_edge[1] + 1) begin
      bad++;
      $display("FAIL back_to_back latency: first output edge %0d, required %0d",
               out_edge.size() ? out_edge[0] : -1, push_edge.size() >= 2 ? push_edge[1] + 1 : -1);
    end
  endtask

  task automatic test_underrun();
    // 4 writes start the frame; the FIFO drains after 4 pops, so a stall of
    // S cycles leaves S-3 empty cycles before sample 5 can be popped.
    int stall = $urandom_range(4, 9);
    clear_sb();
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b0);
    in_valid = 1'b0;
    repeat (stall) step();
    send(DW'($urandom), 1'b0);
    send(DW'($urandom), 1'b1);
    wait_idle();
    check_seq("underrun");
    total++;
    if (n_bubble != stall - 3) begin
      bad++;
      $display("FAIL underrun bubbles: got %0d, required %0d (stall %0d)", n_bubble, stall - 3, stall);
    end
    total++;
    if (n_underrun != stall - 3) begin
      bad++;
      $display("FAIL underrun pulses: got %0d, required %0d", n_underrun, stall - 3);
    end
    total++;
    if (m_flag !== 1'b1) begin
      bad++;
      $display("FAIL underrun flag: got %0b, required 1", m_flag);
    end
  endtask

  task automatic test_random();
    clear_sb();
    for (int f = 0; f < 5; f++) begin
      int len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) step();
        end
        send(DW'($urandom), i == len - 1);
      end
    end
    wait_idle();
    check_seq("random");
    total++;
    if (n_underrun != n_bubble) begin
      bad++;
      $display("FAIL random underrun: got %0d pulses for %0d bubbles, required equal", n_underrun, n_bubble);
    end
    total++;
    if (m_flag !== 1'b1) begin
      bad++;
      $display("FAIL random sticky_flag: got %0b, required 1", m_flag);
    end
  endtask

  task automatic test_small_fifo();
    sel4 = 1'b1;
    clear_sb();
    send(DW'(1), 1'b1);
    for (int i = 0; i < 10; i++) send(DW'(101 + i), i == 9);
    wait_idle();
    check_seq("small_fifo");
    check_contig("small_fifo", 11 + 2 * FLUSH_LEN);
    total++;
    if (n_ready_low == 0) begin
      bad++;
      $display("FAIL small_fifo backpressure: s_ready low for %0d cycles, required >0", n_ready_low);
    end
    sel4 = 1'b0;
  endtask

  task automatic test_reset_flush();
    int guard = 0;
    sel4 = 1'b0;
    clear_sb();
    send(DW'(9), 1'b1);
    send(16'h0033, 1'b0);
    send(16'h0034, 1'b0);
    while (out_data.size() < 3 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL reset_flush wait: got %0d samples, required 3", out_data.size());
    end
    reset = 1'b1;
    step();
    total++;
    if ({m_enable, m_busy, m_done, m_flag, m_ready} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flush outputs: en=%0b busy=%0b done=%0b flag=%0b ready=%0b, required all 0",
               m_enable, m_busy, m_done, m_flag, m_ready);
    end
    reset = 1'b0;
    step();
    clear_sb();
    send(DW'(7), 1'b1);
    wait_idle();
    check_seq("after_reset");
    check_contig("after_reset", 1 + FLUSH_LEN);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sel4 = 1'b0;
    clear_sb();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_random();
    test_small_fifo();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
